// File: rtl/spawn_scheduler.sv
// Spawn scheduler: waits a random number of frame ticks, then offers one spawn
// request (random x and type) to the object manager and re-arms with a new gap.
module spawn_scheduler #(
  parameter int unsigned MIN_GAP = 30,
  parameter int unsigned X_MAX   = 640
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] rand_in,
  input  logic        enable_in,
  input  logic        tick_in,
  input  logic        spawn_ready_in,
  output logic        spawn_valid_out,
  output logic [9:0]  spawn_x_out,
  output logic [1:0]  spawn_type_out,
  output logic [15:0] spawn_count_out,
  output logic [1:0]  dbg_state_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  localparam logic [15:0] MIN_GAP_W = 16'(MIN_GAP);
  localparam logic [19:0] X_MAX_W   = 20'(X_MAX);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        spawn_valid_q, spawn_valid_d;
  logic [9:0]  spawn_x_q, spawn_x_d;
  logic [1:0]  spawn_type_q, spawn_type_d;
  logic [15:0] spawn_count_q, spawn_count_d;

  logic [15:0] gap;
  logic [19:0] x_prod;
  logic        accept;

  // Scaling by X_MAX/1024 maps the 10-bit random field onto 0..X_MAX-1 without a divider.
  assign gap    = MIN_GAP_W + {12'd0, rand_in[5:2]};
  assign x_prod = {10'd0, rand_in[15:6]} * X_MAX_W;

  // Handshake: a request is offered while spawn_valid_out=1 with x/type held
  // stable; it transfers on any rising edge where valid and ready are both 1.
  assign accept = spawn_valid_q & spawn_ready_in;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    spawn_valid_d = spawn_valid_q;
    spawn_x_d     = spawn_x_q;
    spawn_type_d  = spawn_type_q;
    spawn_count_d = spawn_count_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_in) begin
          cnt_d   = gap;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!enable_in) begin
          cnt_d   = 16'd0;
          state_d = ST_IDLE;
        end else if (tick_in) begin
          if (cnt_q == 16'd1) begin
            state_d       = ST_ISSUE;
            spawn_valid_d = 1'b1;
            spawn_x_d     = x_prod[19:10];
            spawn_type_d  = rand_in[1:0];
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
      end
      ST_ISSUE: begin
        // A pending request is always delivered, even if enable drops meanwhile.
        if (accept) begin
          spawn_valid_d = 1'b0;
          if (spawn_count_q != 16'hFFFF) spawn_count_d = spawn_count_q + 16'd1;
          if (enable_in) begin
            cnt_d   = gap;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d       = ST_IDLE;
        spawn_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 16'd0;
      spawn_valid_q <= 1'b0;
      spawn_x_q     <= 10'd0;
      spawn_type_q  <= 2'd0;
      spawn_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_x_q     <= spawn_x_d;
      spawn_type_q  <= spawn_type_d;
      spawn_count_q <= spawn_count_d;
    end
  end

  assign spawn_valid_out = spawn_valid_q;
  assign spawn_x_out     = spawn_x_q;
  assign spawn_type_out  = spawn_type_q;
  assign spawn_count_out = spawn_count_q;
  assign dbg_state_out   = state_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler: reset table, then hand-written gap,
// back-pressure, disable and saturation sequences.
module tb_spawn_scheduler;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] rand_in;
  logic        enable_in;
  logic        tick_in;
  logic        spawn_ready_in;
  logic        spawn_valid_out;
  logic [9:0]  spawn_x_out;
  logic [1:0]  spawn_type_out;
  logic [15:0] spawn_count_out;
  logic [1:0]  dbg_state_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic        tick;
    logic        rdy;
    logic [15:0] rnd;
    logic        v;
    logic [9:0]  x;
    logic [1:0]  t;
    logic [15:0] c;
    logic [1:0]  s;
  } vec_t;

  vec_t vecs[5];

  spawn_scheduler dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rand_in         (rand_in),
    .enable_in       (enable_in),
    .tick_in         (tick_in),
    .spawn_ready_in  (spawn_ready_in),
    .spawn_valid_out (spawn_valid_out),
    .spawn_x_out     (spawn_x_out),
    .spawn_type_out  (spawn_type_out),
    .spawn_count_out (spawn_count_out),
    .dbg_state_out   (dbg_state_out)
  );

  always #5 clk_in = ~clk_in;

  // Inputs change at a falling edge; outputs are read at the following falling edge.
  task automatic cyc(input logic rst, input logic en, input logic tick,
                     input logic rdy, input logic [15:0] rnd);
    rst_in         = rst;
    enable_in      = en;
    tick_in        = tick;
    spawn_ready_in = rdy;
    rand_in        = rnd;
    @(negedge clk_in);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_vcs(input string name, input logic v, input logic [15:0] c,
                         input logic [1:0] s);
    chk({name, "_valid"}, 32'(spawn_valid_out), 32'(v));
    chk({name, "_count"}, 32'(spawn_count_out), 32'(c));
    chk({name, "_state"}, 32'(dbg_state_out), 32'(s));
  endtask

  // n-1 counted ticks (with idle cycles between) must not raise valid; the nth must.
  task automatic wait_ticks(input string name, input int n, input logic [15:0] last_rnd);
    logic early;
    early = 1'b0;
    for (int i = 1; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
      if (spawn_valid_out !== 1'b0) early = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
      if (spawn_valid_out !== 1'b0) early = 1'b1;
    end
    chk({name, "_no_early_valid"}, 32'(early), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, last_rnd);
    chk({name, "_valid_rise"}, 32'(spawn_valid_out), 32'd1);
    chk({name, "_state_issue"}, 32'(dbg_state_out), 32'(S_ISSUE));
  endtask

  task automatic accept(input string name, input logic en, input logic [15:0] rnd,
                        input logic [15:0] exp_c);
    cyc(1'b0, en, 1'b0, 1'b1, rnd);
    chk_vcs(name, 1'b0, exp_c, en ? S_WAIT : S_IDLE);
  endtask

  initial begin
    logic seen;
    rst_in = 1'b1; enable_in = 1'b0; tick_in = 1'b0; spawn_ready_in = 1'b0; rand_in = 16'h0;
    @(negedge clk_in);

    // Reset with toggling inputs, then release with enable low.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 10'd0, 2'd0, 16'd0, S_IDLE};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 2'd0, 16'd0, S_IDLE};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b0, 10'd0, 2'd0, 16'd0, S_IDLE};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b0, 10'd0, 2'd0, 16'd0, S_IDLE};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 10'd0, 2'd0, 16'd0, S_IDLE};
    for (int i = 0; i < 5; i++) begin
      cyc(vecs[i].rst, vecs[i].en, vecs[i].tick, vecs[i].rdy, vecs[i].rnd);
      chk_vcs($sformatf("vec%0d", i), vecs[i].v, vecs[i].c, vecs[i].s);
      chk($sformatf("vec%0d_x", i), 32'(spawn_x_out), 32'(vecs[i].x));
      chk($sformatf("vec%0d_type", i), 32'(spawn_type_out), 32'(vecs[i].t));
    end

    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'(i * 16'h0101));
      if (spawn_valid_out !== 1'b0 || dbg_state_out !== S_IDLE) seen = 1'b1;
    end
    chk("disabled_100_ticks", 32'(seen), 32'd0);

    // Basic gap: 0004 -> gap 31; FFC3 -> x 639, type 3.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0004);
    chk_vcs("enable", 1'b0, 16'd0, S_WAIT);
    wait_ticks("basic", 31, 16'hFFC3);
    chk("basic_x", 32'(spawn_x_out), 32'd639);
    chk("basic_type", 32'(spawn_type_out), 32'd3);
    chk("basic_count_before", 32'(spawn_count_out), 32'd0);
    accept("basic_accept", 1'b1, 16'h0000, 16'd1);

    // Mid-range x under back-pressure, ticks during ISSUE are not banked.
    wait_ticks("mid", 30, 16'h8000);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, (i % 7) == 0, 1'b0, 16'(i * 16'h1357 + 16'h0F0F));
      chk($sformatf("hold%0d", i), {spawn_valid_out, spawn_x_out, spawn_type_out, spawn_count_out},
          {1'b1, 10'd320, 2'd0, 16'd1});
    end
    accept("mid_accept", 1'b1, 16'h0000, 16'd2);
    wait_ticks("after_bp", 30, 16'h0002);
    chk("after_bp_x", 32'(spawn_x_out), 32'd0);
    chk("after_bp_type", 32'(spawn_type_out), 32'd2);
    accept("after_bp_accept", 1'b1, 16'h0000, 16'd3);

    // Disable at cnt=5 with a coincident tick, then re-enable with gap 45.
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
      if (spawn_valid_out !== 1'b0) seen = 1'b1;
    end
    chk("pre_disable", 32'(seen), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    chk_vcs("disable_wait", 1'b0, 16'd3, S_IDLE);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h003C);
    chk_vcs("reenable", 1'b0, 16'd3, S_WAIT);
    wait_ticks("gap45", 45, 16'h4001);
    chk("gap45_x", 32'(spawn_x_out), 32'd160);
    chk("gap45_type", 32'(spawn_type_out), 32'd1);

    // Disable while a request is pending: still delivered, then IDLE.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk_vcs("issue_dis1", 1'b1, 16'd3, S_ISSUE);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk_vcs("issue_dis2", 1'b1, 16'd3, S_ISSUE);
    accept("issue_dis_accept", 1'b0, 16'h0000, 16'd4);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'(i * 16'h0321));
      if (spawn_valid_out !== 1'b0 || spawn_count_out !== 16'd4) seen = 1'b1;
    end
    chk("idle_200_ticks", 32'(seen), 32'd0);

    // Saturation: preload the accepted-spawn counter near the top.
    force dut.spawn_count_q = 16'hFFFD;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    release dut.spawn_count_q;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    wait_ticks("sat1", 30, 16'h0000);
    accept("sat1_accept", 1'b1, 16'h0000, 16'hFFFE);
    wait_ticks("sat2", 30, 16'h0000);
    accept("sat2_accept", 1'b1, 16'h0000, 16'hFFFF);
    wait_ticks("sat3", 30, 16'h0000);
    accept("sat3_accept", 1'b1, 16'h0000, 16'hFFFF);

    // Reset while a request is pending drops it and clears everything.
    wait_ticks("pre_rst", 30, 16'hFFC3);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    chk_vcs("rst_issue", 1'b0, 16'd0, S_IDLE);
    chk("rst_issue_x", 32'(spawn_x_out), 32'd0);
    chk("rst_issue_type", 32'(spawn_type_out), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk_vcs("post_rst", 1'b0, 16'd0, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
